// File: rtl/cm_pkg.sv
`default_nettype none
// ============================================================================
// Module : cm_pkg
// Brief  : Shared types and constants for the merge/branch handshake stages.
// Rev    : 1.0  initial release
// ============================================================================
package cm_pkg;

   localparam int CM_DATA_W = 8;

   // Source/branch encoding: the branch stage uses the same values for BR.
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } cm_state_t;

endpackage : cm_pkg
`default_nettype wire

// File: rtl/cm_merge_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Combinational two-way round-robin grant (0 = a, 1 = b).
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2
   import cm_pkg::*;
(
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_last,
   output logic o_valid,
   output logic o_grant
);

   logic w_both;

   assign w_both  = i_req_a & i_req_b;
   assign o_valid = i_req_a | i_req_b;

   // Under contention the side that was not served last wins.
   assign o_grant = w_both  ? ((i_last == SEL_A) ? SEL_B : SEL_A)
                  : i_req_b ? SEL_B
                  :           SEL_A;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/cm_merge.sv
`default_nettype none
// ============================================================================
// Module : cm_merge
// Brief  : Clocked two-way Send/Ack merge with round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
module cm_merge
   import cm_pkg::*;
#(
   parameter int DATA_W = CM_DATA_W
) (
   input  logic              CLK,
   input  logic              MR_N,
   input  logic              CM_Send_in_a,
   input  logic [DATA_W-1:0] CM_Data_in_a,
   output logic              CM_Ack_out_a,
   input  logic              CM_Send_in_b,
   input  logic [DATA_W-1:0] CM_Data_in_b,
   output logic              CM_Ack_out_b,
   output logic              CM_Send_out,
   output logic [DATA_W-1:0] CM_Data_out,
   output logic              CM_Sel_out,
   input  logic              CM_Ack_in,
   output logic              CM_CP
);

   cm_state_t         r_state;
   logic              r_last;
   logic              r_sel;
   logic [DATA_W-1:0] r_data;
   logic              r_send;
   logic              r_ack_a;
   logic              r_ack_b;
   logic              r_cp;

   logic              w_valid;
   logic              w_grant;
   logic              w_send_g;

   rr_arb2 u_arb (
      .i_req_a (CM_Send_in_a),
      .i_req_b (CM_Send_in_b),
      .i_last  (r_last),
      .o_valid (w_valid),
      .o_grant (w_grant)
   );

   // Request line of the channel currently being served.
   assign w_send_g = (r_sel == SEL_B) ? CM_Send_in_b : CM_Send_in_a;

   always_ff @(posedge CLK) begin
      if (!MR_N) begin
         r_state <= ST_IDLE;
         r_last  <= SEL_B;
         r_sel   <= SEL_A;
         r_data  <= '0;
         r_send  <= 1'b0;
         r_ack_a <= 1'b0;
         r_ack_b <= 1'b0;
         r_cp    <= 1'b0;
      end else begin
         r_cp <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_sel   <= w_grant;
                  r_data  <= (w_grant == SEL_B) ? CM_Data_in_b : CM_Data_in_a;
                  r_ack_a <= (w_grant == SEL_A);
                  r_ack_b <= (w_grant == SEL_B);
                  r_send  <= 1'b1;
                  r_cp    <= 1'b1;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (CM_Ack_in) begin
                  r_send  <= 1'b0;
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Both return-to-zero halves must be seen before releasing.
               if (!CM_Ack_in && !w_send_g) begin
                  r_ack_a <= 1'b0;
                  r_ack_b <= 1'b0;
                  r_last  <= r_sel;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign CM_Ack_out_a = r_ack_a;
   assign CM_Ack_out_b = r_ack_b;
   assign CM_Send_out  = r_send;
   assign CM_Data_out  = r_data;
   assign CM_Sel_out   = r_sel;
   assign CM_CP        = r_cp;

endmodule : cm_merge
`default_nettype wire

// File: tb/tb_cm_merge.sv
`default_nettype none
// ============================================================================
// Module : tb_cm_merge
// Brief  : Self-checking bench for cm_merge: directed cases plus random traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cm_merge;
   import cm_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          mr_n;
   logic          send_a, send_b, ack_in;
   logic [DW-1:0] data_a, data_b;
   logic          ack_a, ack_b, send_out, sel_out, cp;
   logic [DW-1:0] data_out;

   always #5 clk = ~clk;

   cm_merge #(.DATA_W(DW)) dut (
      .CLK          (clk),
      .MR_N         (mr_n),
      .CM_Send_in_a (send_a),
      .CM_Data_in_a (data_a),
      .CM_Ack_out_a (ack_a),
      .CM_Send_in_b (send_b),
      .CM_Data_in_b (data_b),
      .CM_Ack_out_b (ack_b),
      .CM_Send_out  (send_out),
      .CM_Data_out  (data_out),
      .CM_Sel_out   (sel_out),
      .CM_Ack_in    (ack_in),
      .CM_CP        (cp)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Token-level reference: a token is "in flight" from grant until both
   // return-to-zero halves are seen; the downstream request lasts until Ack_in.
   bit            m_valid = 1'b0;
   bit            m_busy, m_send, m_acka, m_ackb, m_sel, m_cp, m_last;
   logic [DW-1:0] m_data;

   always @(posedge clk) begin
      m_cp = 1'b0;
      if (!mr_n) begin
         m_valid = 1'b1;
         m_busy  = 1'b0; m_send = 1'b0; m_acka = 1'b0; m_ackb = 1'b0;
         m_sel   = SEL_A; m_last = SEL_B; m_data = '0;
      end else if (!m_busy) begin
         if (send_a || send_b) begin
            m_sel  = (send_a && send_b) ? !m_last : send_b;
            m_data = m_sel ? data_b : data_a;
            m_acka = !m_sel;
            m_ackb = m_sel;
            m_send = 1'b1;
            m_cp   = 1'b1;
            m_busy = 1'b1;
         end
      end else if (m_send) begin
         if (ack_in) m_send = 1'b0;
      end else if (!ack_in && !(m_sel ? send_b : send_a)) begin
         m_acka = 1'b0;
         m_ackb = 1'b0;
         m_last = m_sel;
         m_busy = 1'b0;
      end
   end

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   bit            sb_en = 1'b0;
   int            ntok  = 0;

   always @(negedge clk) begin
      if (m_valid) begin
         chk("send_out", 32'(send_out), 32'(m_send));
         chk("ack_out_a", 32'(ack_a), 32'(m_acka));
         chk("ack_out_b", 32'(ack_b), 32'(m_ackb));
         chk("sel_out", 32'(sel_out), 32'(m_sel));
         chk("data_out", 32'(data_out), 32'(m_data));
         chk("cp", 32'(cp), 32'(m_cp));
      end
      if (sb_en && cp === 1'b1) begin
         ntok++;
         if (sel_out === SEL_A) begin
            if (qa.size() == 0) chk("sb_a_unexpected", 32'(1), 32'(0));
            else chk("sb_a_data", 32'(data_out), 32'(qa.pop_front()));
         end else begin
            if (qb.size() == 0) chk("sb_b_unexpected", 32'(1), 32'(0));
            else chk("sb_b_data", 32'(data_out), 32'(qb.pop_front()));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      mr_n = 1'b0; send_a = 1'b0; send_b = 1'b0; ack_in = 1'b0;
      tick();
      mr_n = 1'b1;
   endtask

   int ph_a = 0, ph_b = 0, dph = 0;

   task automatic agent_step();
      case (ph_a)
         0: if ($urandom_range(3) == 0) begin
               data_a = 8'($urandom); send_a = 1'b1; qa.push_back(data_a); ph_a = 1;
            end
         1: if (ack_a && $urandom_range(1) == 1) begin send_a = 1'b0; ph_a = 2; end
         default: if (!ack_a) ph_a = 0;
      endcase
      case (ph_b)
         0: if ($urandom_range(3) == 0) begin
               data_b = 8'($urandom); send_b = 1'b1; qb.push_back(data_b); ph_b = 1;
            end
         1: if (ack_b && $urandom_range(1) == 1) begin send_b = 1'b0; ph_b = 2; end
         default: if (!ack_b) ph_b = 0;
      endcase
      if (dph == 0) begin
         if (send_out && $urandom_range(2) == 0) begin ack_in = 1'b1; dph = 1; end
      end else begin
         if (!send_out && $urandom_range(1) == 1) begin ack_in = 1'b0; dph = 0; end
      end
   endtask

   logic [DW-1:0] t3_data[4];
   logic          t3_sel[4];
   int            n;

   initial begin
      mr_n = 1'b0; send_a = 1'b0; send_b = 1'b0; ack_in = 1'b0;
      data_a = '0; data_b = '0;

      // Reset held with a pending request; grant must wait for release.
      send_a = 1'b1; data_a = 8'h33;
      repeat (3) tick();
      chk("t1_rst_send", 32'(send_out), 0);
      chk("t1_rst_acka", 32'(ack_a), 0);
      chk("t1_rst_cp", 32'(cp), 0);
      chk("t1_rst_data", 32'(data_out), 0);
      mr_n = 1'b1;
      tick();
      chk("t1_grant_send", 32'(send_out), 1);
      chk("t1_grant_acka", 32'(ack_a), 1);
      chk("t1_grant_sel", 32'(sel_out), 0);
      chk("t1_grant_data", 32'(data_out), 32'h33);
      tick();
      chk("t1_cp_once", 32'(cp), 0);
      ack_in = 1'b1;
      tick();
      chk("t1_send_drop", 32'(send_out), 0);
      send_a = 1'b0; ack_in = 1'b0;
      tick();
      chk("t1_acka_drop", 32'(ack_a), 0);

      // Single token 0x5A with a two-cycle downstream delay.
      send_a = 1'b1; data_a = 8'h5A;
      tick();
      chk("t2_cp", 32'(cp), 1);
      chk("t2_data", 32'(data_out), 32'h5A);
      chk("t2_sel", 32'(sel_out), 0);
      tick(); tick();
      chk("t2_cp_single", 32'(cp), 0);
      ack_in = 1'b1;
      tick();
      chk("t2_send_drop", 32'(send_out), 0);
      chk("t2_acka_held", 32'(ack_a), 1);
      ack_in = 1'b0;
      tick();
      chk("t2_acka_wait_send", 32'(ack_a), 1);
      send_a = 1'b0; data_a = 8'hFF;
      tick();
      chk("t2_acka_release", 32'(ack_a), 0);
      chk("t2_data_hold", 32'(data_out), 32'h5A);
      tick();
      chk("t2_no_regrant", 32'(send_out), 0);

      // Continuous contention after reset: a,b,a,b.
      do_reset();
      send_a = 1'b1; data_a = 8'h11; send_b = 1'b1; data_b = 8'h22;
      for (int i = 0; i < 4; i++) begin t3_data[i] = 8'hFF; t3_sel[i] = 1'bx; end
      n = 0;
      for (int c = 0; c < 200 && n < 4; c++) begin
         tick();
         if (cp) begin t3_sel[n] = sel_out; t3_data[n] = data_out; n++; end
         if (ack_a && send_a) send_a = 1'b0; else if (!ack_a && !send_a) send_a = 1'b1;
         if (ack_b && send_b) send_b = 1'b0; else if (!ack_b && !send_b) send_b = 1'b1;
         if (send_out && !ack_in) ack_in = 1'b1; else if (!send_out && ack_in) ack_in = 1'b0;
      end
      chk("t3_token_count", 32'(n), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_sel_order", 32'(t3_sel[i]), 32'(i % 2));
         chk("t3_data_order", 32'(t3_data[i]), (i % 2 == 1) ? 32'h22 : 32'h11);
      end

      // Slow release on b: Ack_in gone, Send_in_b held 5 more cycles.
      do_reset();
      send_b = 1'b1; data_b = 8'h77;
      tick();
      chk("t4_sel", 32'(sel_out), 1);
      chk("t4_ackb", 32'(ack_b), 1);
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_ackb_hold", 32'(ack_b), 1);
      end
      send_b = 1'b0;
      tick();
      chk("t4_ackb_release", 32'(ack_b), 0);

      // Serve a once (last=a), then reset mid-ISSUE: last must revert to b.
      send_a = 1'b1; data_a = 8'h01;
      tick(); ack_in = 1'b1;
      tick(); ack_in = 1'b0; send_a = 1'b0;
      tick();
      chk("t5_prep_idle", 32'(ack_a), 0);
      send_a = 1'b1; data_a = 8'h44;
      tick();
      chk("t5_issue", 32'(send_out), 1);
      mr_n = 1'b0;
      tick();
      chk("t5_rst_send", 32'(send_out), 0);
      chk("t5_rst_acka", 32'(ack_a), 0);
      chk("t5_rst_data", 32'(data_out), 0);
      mr_n = 1'b1; send_b = 1'b1; data_b = 8'h55;
      tick();
      chk("t5_grant_sel", 32'(sel_out), 0);
      chk("t5_grant_data", 32'(data_out), 32'h44);
      chk("t5_grant_ackb", 32'(ack_b), 0);

      // Spurious Ack_in in IDLE.
      do_reset();
      ack_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_send", 32'(send_out), 0);
         chk("t6_cp", 32'(cp), 0);
         chk("t6_acks", 32'({ack_a, ack_b}), 0);
      end
      ack_in = 1'b0;

      // Random protocol-compliant traffic against model and scoreboard.
      do_reset();
      qa.delete(); qb.delete();
      ph_a = 0; ph_b = 0; dph = 0;
      sb_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         agent_step();
      end
      sb_en = 1'b0;
      chk("rand_tokens_min", 32'(ntok >= 50), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cm_merge
`default_nettype wire
